// File: rtl/idma_job_arbiter.sv
// idma_job_arbiter
// Round-robin arbiter that sits between several iDMA frontends and a single
// backend. A registered grant is locked until the backend accepts the job.
// The requester ID of every accepted job is queued so that in-order backend
// responses can be routed back to the requester that issued them.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_ARB  | no grant held; pick next valid requester if ID queue has room
// ST_LOCK | grant held; job offered to backend until it is accepted

module idma_job_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned JobWidth       = 128,
  parameter int unsigned RspWidth       = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq*JobWidth-1:0]          req_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  output logic [JobWidth-1:0]                 be_req_o,
  output logic                                be_req_valid_o,
  input  logic                                be_req_ready_i,
  input  logic [RspWidth-1:0]                 be_rsp_i,
  input  logic                                be_rsp_valid_i,
  output logic                                be_rsp_ready_o,
  output logic [RspWidth-1:0]                 rsp_o,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic                                busy_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IdxW-1:0]   r_grant;
  logic [IdxW-1:0]   r_rr_ptr;
  logic [IdxW-1:0]   w_sel;
  logic              w_sel_vld;
  logic              w_grant_load;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [IdxW-1:0]   w_head;
  logic [31:0]       w_job_base;

  logic [IdxW-1:0]   r_ids [MaxOutstanding];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_err;

  assign w_full     = (r_count == CntW'(MaxOutstanding));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_ids[r_rd_ptr];
  assign w_job_base = 32'(r_grant) * JobWidth;

  // (base + off) mod NumReq for off < NumReq
  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return sum[IdxW-1:0];
  endfunction

  // Round-robin pick: first valid requester at or after the pointer
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_sel_vld && req_valid_i[wrap_idx(r_rr_ptr, i)]) begin
        w_sel     = wrap_idx(r_rr_ptr, i);
        w_sel_vld = 1'b1;
      end
    end
  end

  // FSM next state and job-side outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_load   = 1'b0;
    w_push         = 1'b0;
    be_req_valid_o = 1'b0;
    be_req_o       = '0;
    req_ready_o    = '0;
    case (r_state)
      ST_ARB: begin
        // full is judged on registered occupancy, so a same-cycle pop
        // does not open a slot until the following cycle
        if (w_sel_vld && !w_full) begin
          w_state_nxt  = ST_LOCK;
          w_grant_load = 1'b1;
        end
      end
      ST_LOCK: begin
        // grant is held even if the requester drops its valid
        be_req_valid_o       = 1'b1;
        be_req_o             = req_i[w_job_base +: JobWidth];
        req_ready_o[r_grant] = be_req_ready_i;
        if (be_req_ready_i) begin
          w_push      = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // FSM state, held grant and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_ARB;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_load) r_grant <= w_sel;
      if (w_push) begin
        r_rr_ptr <= (r_grant == IdxW'(NumReq - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  // Response routing to the requester at the head of the ID queue
  always_comb begin
    rsp_valid_o    = '0;
    rsp_o          = '0;
    be_rsp_ready_o = 1'b1;
    w_pop          = 1'b0;
    if (!w_empty) begin
      rsp_valid_o[w_head] = be_rsp_valid_i;
      rsp_o               = be_rsp_i;
      be_rsp_ready_o      = rsp_ready_i[w_head];
      w_pop               = be_rsp_valid_i & rsp_ready_i[w_head];
    end
  end

  // Issued-ID queue: pointers wrap naturally, depth is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) r_ids[i] <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wr_ptr] <= r_grant;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag: backend response with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_empty && be_rsp_valid_i) begin
      r_err <= 1'b1;
    end
  end

  assign busy_o        = (r_state == ST_LOCK) || !w_empty;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: tb/tb_idma_job_arbiter.sv
// Directed bench for idma_job_arbiter with job and response scoreboards.
module tb_idma_job_arbiter;

  localparam int NR = 2;
  localparam int JW = 128;
  localparam int RW = 64;
  localparam int MO = 4;

  logic             clk;
  logic             rst;
  logic [NR*JW-1:0] req_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [JW-1:0]    be_req_o;
  logic             be_req_valid_o;
  logic             be_req_ready_i;
  logic [RW-1:0]    be_rsp_i;
  logic             be_rsp_valid_i;
  logic             be_rsp_ready_o;
  logic [RW-1:0]    rsp_o;
  logic [NR-1:0]    rsp_valid_o;
  logic [NR-1:0]    rsp_ready_i;
  logic             busy_o;
  logic [2:0]       outstanding_o;
  logic             err_o;

  idma_job_arbiter #(
    .NumReq(NR), .JobWidth(JW), .RspWidth(RW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .be_req_o(be_req_o), .be_req_valid_o(be_req_valid_o),
    .be_req_ready_i(be_req_ready_i),
    .be_rsp_i(be_rsp_i), .be_rsp_valid_i(be_rsp_valid_i),
    .be_rsp_ready_o(be_rsp_ready_o),
    .rsp_o(rsp_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            last_hs = 0;
  int            n_acc = 0;
  bit            gap_on = 0;
  int            seqn [NR];
  int            left [NR];
  logic [NR-1:0] hs;

  int            exp_req [$];
  logic [JW-1:0] exp_job [$];
  int            exp_dest [$];
  logic [NR-1:0] rsp_log [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [NR-1:0] onehot(input int k);
    logic [NR-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [JW-1:0] mk_job(input int k, input int n);
    return {4{8'(k), 8'(n), 16'hC0DE}};
  endfunction

  task automatic drive_req(input int k);
    req_i[k*JW +: JW] = mk_job(k, seqn[k]);
  endtask

  task automatic set_req(input int k, input int cnt);
    left[k] = cnt;
    req_valid_i[k] = 1'b1;
    drive_req(k);
  endtask

  task automatic expect_job(input int k, input int n);
    exp_req.push_back(k);
    exp_job.push_back(mk_job(k, n));
  endtask

  // Compare current cycle's outputs against the scoreboard; responses are
  // processed before the job push so simultaneous push/pop matches the DUT.
  task automatic sample();
    int d;
    hs = '0;
    chk("outstanding", 128'(outstanding_o), 128'(exp_dest.size()));
    if (exp_dest.size() > 0 && be_rsp_valid_i) begin
      d = exp_dest[0];
      chk("rsp_valid_o", 128'(rsp_valid_o), 128'(onehot(d)));
      chk("rsp_o", 128'(rsp_o), 128'(be_rsp_i));
      chk("be_rsp_ready_o", 128'(be_rsp_ready_o), 128'(rsp_ready_i[d]));
      if (rsp_ready_i[d]) begin
        void'(exp_dest.pop_front());
        rsp_log.push_back(rsp_valid_o);
      end
    end
    if (be_req_valid_o && be_req_ready_i) begin
      if (exp_job.size() == 0) begin
        chk("job_expected", 128'(0), 128'(1));
      end else begin
        chk("be_req_o", be_req_o, exp_job[0]);
        chk("req_ready_o", 128'(req_ready_o), 128'(onehot(exp_req[0])));
        if (gap_on && n_acc > 0) chk("A_gap", 128'(cyc - last_hs), 128'(2));
        last_hs = cyc;
        n_acc++;
        exp_dest.push_back(exp_req[0]);
        void'(exp_req.pop_front());
        void'(exp_job.pop_front());
      end
      hs = req_ready_o;
    end
  endtask

  // One clock: sample before the edge, then advance requester data
  task automatic cycle();
    logic [NR-1:0] h;
    #1;
    sample();
    h = hs;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) begin
      if (h[k]) begin
        seqn[k]++;
        left[k]--;
        if (left[k] <= 0) req_valid_i[k] = 1'b0;
        drive_req(k);
      end
    end
    be_rsp_i = {$urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic run_jobs(input string tag);
    for (int i = 0; i < 60 && exp_job.size() > 0; i++) cycle();
    chk(tag, 128'(exp_job.size()), 128'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_dest.size() > 0 || exp_job.size() > 0); i++) begin
      be_rsp_valid_i = (exp_dest.size() > 0);
      cycle();
    end
    be_rsp_valid_i = 1'b0;
    chk("drain_done", 128'(exp_dest.size() + exp_job.size()), 128'(0));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_be_req_valid"}, 128'(be_req_valid_o), 128'(0));
    chk({pfx, "_req_ready"},    128'(req_ready_o),    128'(0));
    chk({pfx, "_be_req_o"},     be_req_o,             128'(0));
    chk({pfx, "_rsp_valid"},    128'(rsp_valid_o),    128'(0));
    chk({pfx, "_rsp_o"},        128'(rsp_o),          128'(0));
    chk({pfx, "_be_rsp_ready"}, 128'(be_rsp_ready_o), 128'(1));
    chk({pfx, "_busy"},         128'(busy_o),         128'(0));
    chk({pfx, "_outstanding"},  128'(outstanding_o),  128'(0));
    chk({pfx, "_err"},          128'(err_o),          128'(0));
  endtask

  initial begin
    logic [NR-1:0] c_exp [3];
    c_exp = '{2'b01, 2'b10, 2'b01};
    for (int k = 0; k < NR; k++) begin
      seqn[k] = 0;
      left[k] = 0;
    end
    rst            = 1'b1;
    req_i          = '0;
    req_valid_i    = '0;
    be_req_ready_i = 1'b1;
    be_rsp_i       = 64'hDEAD_BEEF_1234_5678;
    be_rsp_valid_i = 1'b0;
    rsp_ready_i    = '1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // A: both requesters continuously valid, backend always ready
    set_req(0, 2);
    set_req(1, 2);
    expect_job(0, 0); expect_job(1, 0); expect_job(0, 1); expect_job(1, 1);
    gap_on = 1; n_acc = 0;
    run_jobs("A_accepted");
    gap_on = 0;
    chk("A_busy", 128'(busy_o), 128'(1));
    drain();
    chk("A_idle", 128'(busy_o), 128'(0));

    // B: queue fills with no responses, then one response frees a slot
    set_req(1, 6);
    for (int i = 0; i < 6; i++) expect_job(1, seqn[1] + i);
    for (int i = 0; i < 20; i++) cycle();
    chk("B_full", 128'(outstanding_o), 128'(4));
    chk("B_no_valid", 128'(be_req_valid_o), 128'(0));
    chk("B_pending", 128'(exp_job.size()), 128'(2));
    be_rsp_valid_i = 1'b1;
    cycle();
    be_rsp_valid_i = 1'b0;
    chk("B_occ3", 128'(outstanding_o), 128'(3));
    chk("B_arb_cycle", 128'(be_req_valid_o), 128'(0));
    cycle();
    chk("B_issue", 128'(be_req_valid_o), 128'(1));
    drain();

    // C: issue order 0,1,0 routes responses back in the same order
    set_req(0, 2);
    set_req(1, 1);
    expect_job(0, seqn[0]); expect_job(1, seqn[1]); expect_job(0, seqn[0] + 1);
    run_jobs("C_accepted");
    rsp_log.delete();
    drain();
    chk("C_rsp_count", 128'(rsp_log.size()), 128'(3));
    for (int i = 0; i < 3 && i < rsp_log.size(); i++) chk("C_rsp_order", 128'(rsp_log[i]), 128'(c_exp[i]));

    // D: backend stalls 5 cycles in LOCK; requester drops valid meanwhile
    be_req_ready_i = 1'b0;
    set_req(0, 1);
    expect_job(0, seqn[0]);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("D_valid", 128'(be_req_valid_o), 128'(1));
      chk("D_stable", be_req_o, mk_job(0, seqn[0]));
      chk("D_ready_low", 128'(req_ready_o), 128'(0));
      if (i == 2) req_valid_i[0] = 1'b0;
      cycle();
    end
    be_req_ready_i = 1'b1;
    #1;
    chk("D_ready_hs", 128'(req_ready_o), 128'(2'b01));
    cycle();
    chk("D_accepted", 128'(exp_job.size()), 128'(0));
    drain();

    // E: spurious response with empty queue
    chk("E_err_before", 128'(err_o), 128'(0));
    be_rsp_valid_i = 1'b1;
    #1;
    chk("E_drain_ready", 128'(be_rsp_ready_o), 128'(1));
    chk("E_rsp_valid", 128'(rsp_valid_o), 128'(0));
    cycle();
    be_rsp_valid_i = 1'b0;
    chk("E_err_set", 128'(err_o), 128'(1));
    chk("E_occ", 128'(outstanding_o), 128'(0));
    repeat (3) cycle();
    chk("E_err_sticky", 128'(err_o), 128'(1));

    // F: asynchronous reset with occupancy 3 while a grant is held
    set_req(0, 4);
    for (int i = 0; i < 4; i++) expect_job(0, seqn[0] + i);
    for (int i = 0; i < 30 && exp_dest.size() < 3; i++) cycle();
    be_req_ready_i = 1'b0;
    cycle();
    chk("F_lock", 128'(be_req_valid_o), 128'(1));
    chk("F_occ3", 128'(outstanding_o), 128'(3));
    rst = 1'b1;
    #1;
    chk_reset_outputs("F");
    exp_dest.delete();
    exp_job.delete();
    exp_req.delete();
    req_valid_i = '0;
    for (int k = 0; k < NR; k++) left[k] = 0;
    @(negedge clk);
    rst = 1'b0;

    // After reset the round-robin pointer starts at requester 0 again
    be_req_ready_i = 1'b1;
    set_req(0, 1);
    set_req(1, 1);
    expect_job(0, seqn[0]); expect_job(1, seqn[1]);
    run_jobs("post_reset_accepted");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
